// File: rtl/sonar_scan_scheduler.sv
// Round-robin ultrasonic ranging controller: triggers each sensor in turn, times the echo,
// publishes distance and timeout results, and keeps per-sensor crash flags.
module sonar_scan_scheduler #(
    parameter int N_SENSORS      = 3,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3000000,
    parameter int GAP_CYCLES     = 1000000,
    parameter int CRASH_THRESH   = 294117,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trigger,
    output logic [2:0]           sel,
    output logic                 busy,
    output logic                 dist_valid,
    output logic [CNT_W-1:0]     dist_value,
    output logic [2:0]           dist_id,
    output logic                 timeout,
    output logic [N_SENSORS-1:0] crash
);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    localparam logic [31:0]      TRIG_LAST    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_THRESH   = CNT_W'(CRASH_THRESH);
    localparam logic [2:0]       LAST_SEL     = 3'(N_SENSORS - 1);

    state_t               state;
    state_t               state_next;
    logic [31:0]          timer;
    logic [CNT_W-1:0]     count;
    logic [N_SENSORS-1:0] echo_meta;
    logic [N_SENSORS-1:0] echo_sync;
    logic [7:0]           echo_wide;
    logic                 es;
    logic                 es_prev;
    logic                 trig_done;
    logic                 gap_done;
    logic                 shot_expired;
    logic                 meas_done;
    logic                 meas_expired;
    logic [2:0]           sel_adv;

    // Widen the synchronized echoes to 8 bits so sel can index them directly.
    always_comb begin
        echo_wide = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            echo_wide[i] = echo_sync[i];
        end
    end

    assign es = echo_wide[sel];

    always_comb begin
        trig_done    = (timer == TRIG_LAST);
        gap_done     = (timer == GAP_LAST);
        shot_expired = (timer == TIMEOUT_LAST);
        sel_adv      = (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;
    end

    always_comb begin
        state_next   = state;
        meas_done    = 1'b0;
        meas_expired = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = TRIG;
            end
            TRIG: begin
                if (trig_done) state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (shot_expired) begin
                    meas_expired = 1'b1;
                    state_next   = GAP;
                end else if (es && !es_prev) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                // A falling echo on the expiry cycle still counts as a valid measurement.
                if (!es) begin
                    meas_done  = 1'b1;
                    state_next = GAP;
                end else if (shot_expired) begin
                    meas_expired = 1'b1;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_done) state_next = enable ? TRIG : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        trigger = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            trigger[i] = (state == TRIG) && (sel == 3'(i));
        end
    end

    // The shot timer keeps running from WAIT_RISE into MEASURE so the timeout spans both.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            count      <= '0;
            echo_meta  <= '0;
            echo_sync  <= '0;
            es_prev    <= 1'b0;
            sel        <= '0;
            dist_valid <= 1'b0;
            dist_value <= '0;
            dist_id    <= '0;
            timeout    <= 1'b0;
            crash      <= '0;
        end else begin
            state      <= state_next;
            echo_meta  <= echo;
            echo_sync  <= echo_meta;
            es_prev    <= es;
            dist_valid <= meas_done;
            timeout    <= meas_expired;

            if (state_next != state && state_next != MEASURE) begin
                timer <= '0;
            end else if (state != IDLE) begin
                timer <= timer + 32'd1;
            end

            if (state == WAIT_RISE && state_next == MEASURE) begin
                count <= CNT_W'(1);
            end else if (state == MEASURE && es && count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end

            if (meas_done) begin
                dist_value <= count;
                dist_id    <= sel;
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (sel == 3'(i)) crash[i] <= (count <= CNT_THRESH);
                end
            end else if (meas_expired) begin
                dist_value <= CNT_MAX;
                dist_id    <= sel;
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (sel == 3'(i)) crash[i] <= 1'b0;
                end
            end

            if (state == GAP && gap_done) begin
                sel <= sel_adv;
            end
        end
    end

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Directed bench for sonar_scan_scheduler: a scoreboard queue holds the expected result of
// each shot and a negedge monitor pops and compares it whenever the DUT reports a result.
module tb_sonar_scan_scheduler;

    localparam int N       = 3;
    localparam int TRIG    = 10;
    localparam int TMO     = 200;
    localparam int GAP     = 20;
    localparam int THRESH  = 50;
    localparam int CNT_W   = 32;

    typedef struct {
        bit          is_timeout;
        logic [31:0] value;
        logic [2:0]  id;
        bit          crash;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [N-1:0]     echo;
    logic [N-1:0]     trigger;
    logic [2:0]       sel;
    logic             busy;
    logic             dist_valid;
    logic [CNT_W-1:0] dist_value;
    logic [2:0]       dist_id;
    logic             timeout;
    logic [N-1:0]     crash;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [N-1:0]     exp_crash;
    int               checks;
    int               errors;
    int               n;

    sonar_scan_scheduler #(
        .N_SENSORS(N),
        .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES(GAP),
        .CRASH_THRESH(THRESH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .echo(echo),
        .trigger(trigger),
        .sel(sel),
        .busy(busy),
        .dist_valid(dist_valid),
        .dist_value(dist_value),
        .dist_id(dist_id),
        .timeout(timeout),
        .crash(crash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic waitTrigStart(output int cnt);
        cnt = 0;
        while (trigger == '0 && cnt < 500) begin
            tick();
            cnt++;
        end
        checkOutput("trigger_start_seen", 64'(trigger != '0), 64'd1);
    endtask

    task automatic countTrig(output int cnt);
        cnt = 0;
        while (trigger != '0 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic waitDone(output int cnt);
        cnt = 0;
        while (!dist_valid && !timeout && cnt < 1000) begin
            tick();
            cnt++;
        end
        checkOutput("result_seen", 64'(dist_valid || timeout), 64'd1);
    endtask

    task automatic countGapToTrig(output int cnt);
        cnt = 0;
        while (trigger == '0 && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    // Drives one echo pulse and records the result the scheduler should publish for it.
    task automatic applyStimulus(input int sensor, input int delay, input int high);
        exp_t e;
        e.is_timeout = 1'b0;
        e.value      = 32'(high);
        e.id         = 3'(sensor);
        e.crash      = (high <= THRESH);
        sb.push_back(e);
        repeat (delay) tick();
        echo[sensor] = 1'b1;
        repeat (high) tick();
        echo[sensor] = 1'b0;
    endtask

    // Scoreboard monitor: every dist_valid/timeout pulse must match the oldest expected shot.
    always @(negedge clk) begin
        if (rst) begin
            exp_crash = '0;
        end else if (dist_valid || timeout) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {62'd0, dist_valid, timeout}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                exp_crash[mon_e.id] = mon_e.crash;
                checkOutput("sb_dist_valid", 64'(dist_valid), 64'(!mon_e.is_timeout));
                checkOutput("sb_timeout", 64'(timeout), 64'(mon_e.is_timeout));
                checkOutput("sb_dist_value", 64'(dist_value), 64'(mon_e.value));
                checkOutput("sb_dist_id", 64'(dist_id), 64'(mon_e.id));
                checkOutput("sb_crash", 64'(crash), 64'(exp_crash));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) tick();

        checkOutput("rst_trigger", 64'(trigger), 64'd0);
        checkOutput("rst_sel", 64'(sel), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_dist_valid", 64'(dist_valid), 64'd0);
        checkOutput("rst_dist_value", 64'(dist_value), 64'd0);
        checkOutput("rst_dist_id", 64'(dist_id), 64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        checkOutput("rst_crash", 64'(crash), 64'd0);

        rst = 1'b0;
        repeat (3) tick();
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] sensor 0 shot, 40-cycle echo");
        enable = 1'b1;
        waitTrigStart(n);
        checkOutput("s0_trigger", 64'(trigger), 64'b001);
        checkOutput("s0_busy", 64'(busy), 64'd1);
        checkOutput("s0_sel", 64'(sel), 64'd0);
        countTrig(n);
        checkOutput("s0_trig_width", 64'(n), 64'(TRIG));
        applyStimulus(0, 5, 40);
        waitDone(n);
        countGapToTrig(n);
        checkOutput("s0_gap_len", 64'(n), 64'(GAP));
        checkOutput("s1_trigger", 64'(trigger), 64'b010);

        $display("[TB] sensor 1 shot, 80-cycle echo");
        countTrig(n);
        checkOutput("s1_trig_width", 64'(n), 64'(TRIG));
        applyStimulus(1, 7, 80);
        waitDone(n);
        countGapToTrig(n);
        checkOutput("s1_gap_len", 64'(n), 64'(GAP));
        checkOutput("s2_trigger", 64'(trigger), 64'b100);
        checkOutput("s2_sel", 64'(sel), 64'd2);

        $display("[TB] sensor 2 shot, no echo");
        countTrig(n);
        sb.push_back('{1'b1, 32'hFFFF_FFFF, 3'd2, 1'b0});
        n = 0;
        while (!timeout && n < 400) begin
            tick();
            n++;
        end
        checkOutput("s2_timeout_delay", 64'(n), 64'(TMO));
        countGapToTrig(n);
        checkOutput("wrap_gap_len", 64'(n), 64'(GAP));
        checkOutput("wrap_trigger", 64'(trigger), 64'b001);
        checkOutput("wrap_sel", 64'(sel), 64'd0);

        $display("[TB] sensor 0 echo falls on the expiry cycle, echo[1] toggling");
        countTrig(n);
        for (int i = 0; i < 9; i++) begin
            echo[1] = i[0];
            tick();
        end
        echo[1] = 1'b0;
        tick();
        sb.push_back('{1'b0, 32'd187, 3'd0, 1'b0});
        echo[0] = 1'b1;
        for (int i = 0; i < 187; i++) begin
            echo[1] = (i % 5) < 2;
            tick();
        end
        echo[0] = 1'b0;
        echo[1] = 1'b0;
        waitDone(n);
        countGapToTrig(n);
        checkOutput("edge_next_trigger", 64'(trigger), 64'b010);

        $display("[TB] reset during measurement");
        countTrig(n);
        repeat (5) tick();
        echo[1] = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_trigger", 64'(trigger), 64'd0);
        checkOutput("midrst_sel", 64'(sel), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_dist_valid", 64'(dist_valid), 64'd0);
        checkOutput("midrst_dist_value", 64'(dist_value), 64'd0);
        checkOutput("midrst_dist_id", 64'(dist_id), 64'd0);
        checkOutput("midrst_timeout", 64'(timeout), 64'd0);
        checkOutput("midrst_crash", 64'(crash), 64'd0);
        echo[1] = 1'b0;
        enable  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("postrst_busy", 64'(busy), 64'd0);

        $display("[TB] enable dropped mid-shot");
        enable = 1'b1;
        waitTrigStart(n);
        checkOutput("en_trigger", 64'(trigger), 64'b001);
        countTrig(n);
        enable = 1'b0;
        applyStimulus(0, 3, 30);
        waitDone(n);
        repeat (25) tick();
        checkOutput("en_idle_busy", 64'(busy), 64'd0);
        checkOutput("en_idle_sel", 64'(sel), 64'd1);
        checkOutput("en_idle_trigger", 64'(trigger), 64'd0);
        repeat (5) tick();
        checkOutput("en_idle_hold_busy", 64'(busy), 64'd0);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sonar_scan_scheduler.md
Name: sonar_scan_scheduler

Overview:
Round-robin controller that shares one ranging engine across N ultrasonic proximity sensors on the rover.
- Per sensor in turn: fires a trigger pulse, measures echo high-time in clk cycles, applies a crash threshold, and publishes the result.
- Enforces an inter-shot gap so one sensor's ringing is not read as another sensor's echo.
- Feeds per-sensor crash flags to the motor control block.

Parameters:
N_SENSORS, 3, number of sensors scanned (1..8)
TRIG_CYCLES, 1000, trigger pulse width in clk cycles (10 us at 100 MHz)
TIMEOUT_CYCLES, 3000000, max cycles from trigger end to echo fall before the shot is abandoned (30 ms)
GAP_CYCLES, 1000000, idle cycles after each shot before the next trigger (10 ms)
CRASH_THRESH, 294117, echo count at or below which the sensor reports crash
CNT_W, 32, width of the echo counter and of dist_value

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
enable  in  1  scanning allowed while high
echo  in  N_SENSORS  raw asynchronous echo lines, one per sensor
trigger  out  N_SENSORS  trigger outputs, at most one bit high at any time
sel  out  3  index of the sensor currently being serviced
busy  out  1  high in every state except IDLE
dist_valid  out  1  one-cycle pulse when a measurement completes
dist_value  out  CNT_W  echo high-time in cycles; holds until the next dist_valid or timeout
dist_id  out  3  sensor index for dist_value
timeout  out  1  one-cycle pulse when a shot is abandoned
crash  out  N_SENSORS  per-sensor crash flag, updated only at shot completion

Behaviour:
Reset:
- rst sampled at posedge clk.
- All outputs go to 0 next edge: trigger, sel, busy, dist_valid, dist_value, dist_id, timeout, crash.
- FSM goes to IDLE. Echo synchronizers are cleared.
- rst mid-shot drops trigger on the same edge. No dist_valid or timeout is emitted for the aborted shot.

Echo input:
- Each echo bit passes through a 2-flop synchronizer. es denotes the synchronized bit for sel.
- Echo bits of non-selected sensors are ignored.

FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE: busy=0. If enable=1, go to TRIG next cycle and keep the current sel.
- TRIG: trigger[sel]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE. The timer clears on entry to WAIT_RISE.
- WAIT_RISE: waits for a 0->1 edge on es. An es already high on entry does not count; it must fall and rise again. On the rise, go to MEASURE with the counter at 1.
- MEASURE: the counter increments every cycle es=1 and saturates at all-ones. The cycle es is first seen 0:
  - dist_valid=1, dist_value=counter, dist_id=sel.
  - crash[sel] = (counter <= CRASH_THRESH).
  - Go to GAP.
- Timeout: the timer counts every cycle in WAIT_RISE and MEASURE. When it reaches TIMEOUT_CYCLES:
  - timeout=1, dist_value=all-ones, dist_id=sel, crash[sel]=0.
  - Go to GAP. No dist_valid is emitted.
  - If echo fall and timeout occur in the same cycle, the fall wins.
- GAP: stays GAP_CYCLES cycles. On exit, sel advances (N_SENSORS-1 wraps to 0). Next state is TRIG if enable=1, else IDLE.
- Deasserting enable mid-shot does not abort; the shot and its gap complete first.

Other rules:
- Latency: a physical echo fall is reported 3 cycles later (2 sync + 1 registered output).
- crash bits of other sensors hold their values across shots.
- N_SENSORS=1 scans sensor 0 repeatedly.

Test Plan:
Bench parameters: N_SENSORS=3, TRIG_CYCLES=10, TIMEOUT_CYCLES=200, GAP_CYCLES=20, CRASH_THRESH=50.
- Reset then enable=1 -> trigger=001 for exactly 10 cycles; busy=1; sel=0.
- Sensor 0 echo high 40 cycles -> dist_valid pulse, dist_value=40, dist_id=0, crash[0]=1; after 20 gap cycles trigger=010.
- Sensor 1 echo high 80 cycles -> dist_value=80, crash[1]=0, crash[0] still 1.
- Sensor 2 never echoes -> timeout pulse 200 cycles after trigger end, dist_value=FFFFFFFF, crash[2]=0, no dist_valid; sel wraps to 0.
- Echo fall on the exact timeout cycle -> dist_valid only, no timeout. Echo[1] toggling while sel=0 -> no effect.
- rst mid-MEASURE -> all outputs 0 next edge, no pulse. Separately, enable=0 mid-shot -> shot completes, then IDLE with busy=0 and sel advanced.
